rvv_backend_mulmac_sched: RTL and testbench

//  Issue scheduler for the MUL/MAC execution pair. Inspects the two head uops of the MUL reservation-station FIFO.

---
 rtl/rvv_backend_mulmac_sched_if.sv | 28 ++
 rtl/rvv_backend_mulmac_sched.sv | 105 ++++++++++
 tb/tb_rvv_backend_mulmac_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rvv_backend_mulmac_sched_if.sv
// rtl/rvv_backend_mulmac_sched_if.sv - RS head / issue / retire bundle between MUL RS FIFO, MUL/MAC pipes and ROB
// master is the RS/ROB side, slave is the scheduler.
interface rvv_backend_mulmac_sched_if;
    logic       rs_fifo_empty;
    logic       rs_fifo_1left_to_empty;
    logic       rs_uop0_is_mac;
    logic       rs_uop1_is_mac;
    logic       flush;
    logic       mul_retire;
    logic       mac_retire;
    logic [1:0] rs_fifo_pop;
    logic       mul_issue_valid;
    logic       mul_issue_sel;
    logic       mac_issue_valid;
    logic       mac_issue_sel;

    modport master (
        output rs_fifo_empty, rs_fifo_1left_to_empty, rs_uop0_is_mac, rs_uop1_is_mac,
        output flush, mul_retire, mac_retire,
        input  rs_fifo_pop, mul_issue_valid, mul_issue_sel, mac_issue_valid, mac_issue_sel
    );

    modport slave (
        input  rs_fifo_empty, rs_fifo_1left_to_empty, rs_uop0_is_mac, rs_uop1_is_mac,
        input  flush, mul_retire, mac_retire,
        output rs_fifo_pop, mul_issue_valid, mul_issue_sel, mac_issue_valid, mac_issue_sel
    );
endinterface

// File: rtl/rvv_backend_mulmac_sched.sv
// rtl/rvv_backend_mulmac_sched.sv - credit-gated in-order MUL/MAC issue scheduler for the MUL RS FIFO
// Steers the two RS heads to the MUL/MAC pipes and tracks per-pipe result credits against ROB retire.
module rvv_backend_mulmac_sched #(
    parameter int MUL_CREDITS = 4,
    parameter int MAC_CREDITS = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    rvv_backend_mulmac_sched_if.slave     sched,
    output logic                          idle,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    localparam logic [3:0] MUL_FULL = 4'(MUL_CREDITS);
    localparam logic [3:0] MAC_FULL = 4'(MAC_CREDITS);

    logic [3:0]             mul_cred_q, mul_cred_d;
    logic [3:0]             mac_cred_q, mac_cred_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic v0, v1, mul_ok, mac_ok;
    logic u0_mul, u0_mac, u1_mul, u1_mac;
    logic mul_iss, mac_iss, mul_ret_ok, mac_ret_ok;

    assign v0     = !sched.rs_fifo_empty;
    assign v1     = !(sched.rs_fifo_empty | sched.rs_fifo_1left_to_empty);
    assign mul_ok = (mul_cred_q != 4'd0);
    assign mac_ok = (mac_cred_q != 4'd0);

    always_comb begin
        u0_mul = 1'b0;
        u0_mac = 1'b0;
        u1_mul = 1'b0;
        u1_mac = 1'b0;
        if (!rst && !sched.flush && v0) begin
            if (sched.rs_uop0_is_mac) begin
                u0_mac = mac_ok;
            end else if (mul_ok) begin
                u0_mul = 1'b1;
            end else begin
                u0_mac = mac_ok;
            end
            // uop1 only ever takes the pipe uop0 left free, keeping pops in order
            if (v1) begin
                if (u0_mul) begin
                    u1_mac = mac_ok;
                end else if (u0_mac && !sched.rs_uop1_is_mac) begin
                    u1_mul = mul_ok;
                end
            end
        end
    end

    assign mul_iss               = u0_mul | u1_mul;
    assign mac_iss               = u0_mac | u1_mac;
    assign sched.mul_issue_valid = mul_iss;
    assign sched.mul_issue_sel   = u1_mul;
    assign sched.mac_issue_valid = mac_iss;
    assign sched.mac_issue_sel   = u1_mac;
    assign sched.rs_fifo_pop     = {u1_mul | u1_mac, u0_mul | u0_mac};

    // A retire against a full counter has nothing to return; it is dropped.
    assign mul_ret_ok = sched.mul_retire && (mul_cred_q != MUL_FULL);
    assign mac_ret_ok = sched.mac_retire && (mac_cred_q != MAC_FULL);

    always_comb begin
        mul_cred_d  = mul_cred_q - {3'b000, mul_iss} + {3'b000, mul_ret_ok};
        mac_cred_d  = mac_cred_q - {3'b000, mac_iss} + {3'b000, mac_ret_ok};
        stall_cnt_d = stall_cnt_q;
        if (sched.flush) begin
            mul_cred_d = MUL_FULL;
            mac_cred_d = MAC_FULL;
        end else if (v0 && !sched.rs_fifo_pop[0] && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cred_q  <= MUL_FULL;
            mac_cred_q  <= MAC_FULL;
            stall_cnt_q <= '0;
        end else begin
            mul_cred_q  <= mul_cred_d;
            mac_cred_q  <= mac_cred_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign idle      = !rst && (mul_cred_q == MUL_FULL) && (mac_cred_q == MAC_FULL);
    assign stall_cnt = stall_cnt_q;

    a_pop_order: assert property (@(posedge clk) disable iff (rst)
        sched.rs_fifo_pop[1] |-> sched.rs_fifo_pop[0]);
    a_sel_distinct: assert property (@(posedge clk) disable iff (rst)
        !(sched.mul_issue_valid && sched.mac_issue_valid && (sched.mul_issue_sel == sched.mac_issue_sel)));
    a_mul_non_mac: assert property (@(posedge clk) disable iff (rst)
        sched.mul_issue_valid |-> (sched.mul_issue_sel ? !sched.rs_uop1_is_mac : !sched.rs_uop0_is_mac));
    a_mul_retire_ok: assert property (@(posedge clk) disable iff (rst || sched.flush)
        sched.mul_retire |-> (mul_cred_q != MUL_FULL));
    a_mac_retire_ok: assert property (@(posedge clk) disable iff (rst || sched.flush)
        sched.mac_retire |-> (mac_cred_q != MAC_FULL));

endmodule

// File: tb/tb_rvv_backend_mulmac_sched.sv
// tb/tb_rvv_backend_mulmac_sched.sv - directed + random check of rvv_backend_mulmac_sched against an outstanding-count model
// Model tracks uops in flight per pipe and places heads by pipe capability and free slots.
module tb_rvv_backend_mulmac_sched;

    localparam int MUL_CR = 4;
    localparam int MAC_CR = 4;
    localparam int SW     = 16;
    localparam int NONE = 0, PMUL = 1, PMAC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          idle;
    logic [SW-1:0] stall_cnt;

    rvv_backend_mulmac_sched_if sched ();

    rvv_backend_mulmac_sched #(
        .MUL_CREDITS (MUL_CR),
        .MAC_CREDITS (MAC_CR),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sched     (sched.slave),
        .idle      (idle),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mul_out = 0;
    int mac_out = 0;
    int stall   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check combinational outputs and registered status against the model, advance the model.
    task automatic step(input bit r, input int n, input bit m0, input bit m1,
                        input bit fl, input bit mr, input bit cr);
        int  p0, p1;
        bit  mul_free, mac_free;
        @(posedge clk);
        #1;
        rst                          = r;
        sched.rs_fifo_empty          = (n == 0);
        sched.rs_fifo_1left_to_empty = (n == 1);
        sched.rs_uop0_is_mac         = m0;
        sched.rs_uop1_is_mac         = m1;
        sched.flush                  = fl;
        sched.mul_retire             = mr;
        sched.mac_retire             = cr;
        #3;
        mul_free = (mul_out < MUL_CR);
        mac_free = (mac_out < MAC_CR);
        p0 = NONE;
        p1 = NONE;
        if (!r && !fl && n >= 1) begin
            p0 = (!m0 && mul_free) ? PMUL : (mac_free ? PMAC : NONE);
            if (p0 == PMUL && n == 2 && mac_free) p1 = PMAC;
            if (p0 == PMAC && n == 2 && mul_free && !m1) p1 = PMUL;
        end
        chk("pop",       32'(sched.rs_fifo_pop), 32'({p1 != NONE, p0 != NONE}));
        chk("mul_valid", 32'(sched.mul_issue_valid), 32'(p0 == PMUL || p1 == PMUL));
        chk("mac_valid", 32'(sched.mac_issue_valid), 32'(p0 == PMAC || p1 == PMAC));
        if (p1 == PMUL) chk("mul_sel", 32'(sched.mul_issue_sel), 32'd1);
        if (p0 == PMUL) chk("mul_sel", 32'(sched.mul_issue_sel), 32'd0);
        if (p1 == PMAC) chk("mac_sel", 32'(sched.mac_issue_sel), 32'd1);
        if (p0 == PMAC) chk("mac_sel", 32'(sched.mac_issue_sel), 32'd0);
        chk("idle",  32'(idle), 32'(!r && mul_out == 0 && mac_out == 0));
        chk("stall", 32'(stall_cnt), 32'(stall));
        if (r || fl) begin
            mul_out = 0;
            mac_out = 0;
            if (r) stall = 0;
        end else begin
            mul_out += int'(p0 == PMUL) + int'(p1 == PMUL) - int'(mr);
            mac_out += int'(p0 == PMAC) + int'(p1 == PMAC) - int'(cr);
            if (n >= 1 && p0 == NONE && stall < (1 << SW) - 1) stall++;
        end
    endtask

    initial begin
        int n;
        bit fl, mr, cr;
        sched.rs_fifo_empty          = 1'b1;
        sched.rs_fifo_1left_to_empty = 1'b0;
        sched.rs_uop0_is_mac         = 1'b0;
        sched.rs_uop1_is_mac         = 1'b0;
        sched.flush                  = 1'b0;
        sched.mul_retire             = 1'b0;
        sched.mac_retire             = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // two non-MAC heads: both issue, one per pipe
        step(0, 2, 0, 0, 0, 0, 0);
        // both heads MAC: only uop0 goes
        step(0, 2, 1, 1, 0, 0, 0);
        // drain MUL credits (mul_out 1 -> 4), then non-MAC uop0 spills to MAC
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 2, 0, 0, 0, 0, 0);
        // fill MAC credits, then retire against an empty credit: no bypass
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        // flush with a retire; everything returns full and idle
        step(0, 2, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            n  = ($urandom_range(0, 9) < 2) ? 0 : (($urandom_range(0, 9) < 4) ? 1 : 2);
            fl = ($urandom_range(0, 59) == 0);
            mr = (mul_out > 0) && ($urandom_range(0, 99) < 40);
            cr = (mac_out > 0) && ($urandom_range(0, 99) < 40);
            step($urandom_range(0, 199) == 0, n, 1'($urandom), 1'($urandom), fl, mr, cr);
        end

        // saturate the stall counter with a MAC head starved of credits
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAC_CR; i++) step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65545; i++) step(0, 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #4;
        chk("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
